// File: rtl/imm_extend_pipe.sv
// LEGv8 immediate generator: extracts the immediate field, extends it to DATA_W bits and shifts it.
// Two-stage valid/ready pipeline with synchronous flush.
module imm_extend_pipe #(
    parameter int DATA_W   = 64,
    parameter bit D_SIGNED = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       instr,
    input  logic [2:0]        fmt,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] imm,
    output logic              err
);

    typedef enum logic [2:0] {
        FMT_D     = 3'd0,
        FMT_I     = 3'd1,
        FMT_B     = 3'd2,
        FMT_CB    = 3'd3,
        FMT_IW    = 3'd4,
        FMT_SHAMT = 3'd5
    } fmt_e;

    logic              s1_valid_q, s2_valid_q;
    logic [25:0]       raw_q, raw_d;
    logic [2:0]        fmt_q;
    logic [1:0]        hw_q;
    logic [DATA_W-1:0] imm_q, imm_d;
    logic              err_q, err_d;
    logic [63:0]       ext_full;
    logic              s1_load, s2_load;
    logic              unused_instr;

    assign s2_load  = !s2_valid_q || out_ready;
    assign s1_load  = !s1_valid_q || s2_load;
    assign in_ready = s1_load && !flush;

    assign out_valid = s2_valid_q;
    assign imm       = imm_q;
    assign err       = err_q;

    assign unused_instr = ^instr[31:26];

    // Stage 1 keeps only the raw field, right-aligned and zero-padded.
    always_comb begin
        raw_d = '0;
        case (fmt)
            FMT_D:     raw_d = {17'b0, instr[20:12]};
            FMT_I:     raw_d = {14'b0, instr[21:10]};
            FMT_B:     raw_d = instr[25:0];
            FMT_CB:    raw_d = {7'b0, instr[23:5]};
            FMT_IW:    raw_d = {10'b0, instr[20:5]};
            FMT_SHAMT: raw_d = {20'b0, instr[15:10]};
            default:   raw_d = '0;
        endcase
    end

    // Built at 64 bits and truncated; identical to extending to DATA_W then shifting.
    always_comb begin
        ext_full = '0;
        err_d    = 1'b0;
        case (fmt_q)
            FMT_D:  ext_full = D_SIGNED ? {{55{raw_q[8]}}, raw_q[8:0]} : {55'b0, raw_q[8:0]};
            FMT_I:  ext_full = {52'b0, raw_q[11:0]};
            FMT_B:  ext_full = {{36{raw_q[25]}}, raw_q[25:0], 2'b00};
            FMT_CB: ext_full = {{43{raw_q[18]}}, raw_q[18:0], 2'b00};
            FMT_IW: begin
                if (DATA_W == 32 && hw_q[1]) begin
                    err_d = 1'b1;
                end else begin
                    ext_full = {48'b0, raw_q[15:0]} << {hw_q, 4'b0000};
                end
            end
            FMT_SHAMT: begin
                if (DATA_W == 32 && raw_q[5]) begin
                    err_d = 1'b1;
                end else begin
                    ext_full = {58'b0, raw_q[5:0]};
                end
            end
            default: err_d = 1'b1;
        endcase
        imm_d = ext_full[DATA_W-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            raw_q      <= '0;
            fmt_q      <= '0;
            hw_q       <= '0;
            imm_q      <= '0;
            err_q      <= 1'b0;
        end else if (flush) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
        end else begin
            if (s2_load) begin
                s2_valid_q <= s1_valid_q;
                if (s1_valid_q) begin
                    imm_q <= imm_d;
                    err_q <= err_d;
                end
            end
            if (s1_load) begin
                s1_valid_q <= in_valid;
                if (in_valid) begin
                    raw_q <= raw_d;
                    fmt_q <= fmt;
                    hw_q  <= instr[22:21];
                end
            end
        end
    end

endmodule
